// File: rtl/exe_stage_mc.sv
`default_nettype none
// ============================================================================
// exe_stage_mc : registered ARM execute stage with iterative multiplier,
//                status register and valid/ready/freeze handshake.
// Revision 1.0 : initial release
// ============================================================================
module exe_stage_mc #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             ready,
  input  logic             freeze,
  input  logic [3:0]       exe_cmd,
  input  logic             mul_en,
  input  logic             s_bit,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val_rm,
  input  logic             imm,
  input  logic [11:0]      shift_operand,
  input  logic [23:0]      signed_imm_24,
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [WIDTH-1:0] mem_fwd,
  input  logic [WIDTH-1:0] wb_fwd,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] val_rm_out,
  output logic [WIDTH-1:0] br_addr,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic [3:0]       status
);

  localparam int c_iters = WIDTH / MUL_BITS;
  localparam int c_cnt_w = $clog2(c_iters + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_mul_rm;
  logic               r_mul_s;

  logic [WIDTH-1:0] w_in1;
  logic [WIDTH-1:0] w_rm_f;
  logic [WIDTH-1:0] w_val2;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_c;
  logic             w_v;
  logic [WIDTH-1:0] w_pp;
  logic [WIDTH-1:0] w_br;
  logic             w_accept;

  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input int unsigned r);
    int unsigned rr;
    rr = r % WIDTH;
    return (x >> rr) | (x << (WIDTH - rr));
  endfunction

  assign ready    = (r_state == S_IDLE) && !freeze;
  assign w_accept = in_valid && ready;

  always_comb begin
    case (sel_src1)
      2'd1:    w_in1 = mem_fwd;
      2'd2:    w_in1 = wb_fwd;
      default: w_in1 = val_rn;
    endcase
    case (sel_src2)
      2'd1:    w_rm_f = mem_fwd;
      2'd2:    w_rm_f = wb_fwd;
      default: w_rm_f = val_rm;
    endcase
  end

  always_comb begin
    w_val2 = '0;
    if (mem_r_en || mem_w_en) begin
      w_val2 = {{(WIDTH-12){1'b0}}, shift_operand};
    end else if (imm) begin
      w_val2 = ror({{(WIDTH-8){1'b0}}, shift_operand[7:0]}, 2 * int'(shift_operand[11:8]));
    end else begin
      case (shift_operand[6:5])
        2'b00:   w_val2 = w_rm_f << shift_operand[11:7];
        2'b01:   w_val2 = w_rm_f >> shift_operand[11:7];
        2'b10:   w_val2 = $unsigned($signed(w_rm_f) >>> shift_operand[11:7]);
        default: w_val2 = ror(w_rm_f, int'(shift_operand[11:7]));
      endcase
    end
  end

  // Carry-in is SR.C; subtraction is in1 + ~val2 + 1 so carry out is NOT borrow.
  always_comb begin
    w_res = '0;
    w_sum = '0;
    w_c   = status[1];
    w_v   = status[0];
    case (exe_cmd)
      4'b0001: w_res = w_val2;
      4'b1001: w_res = ~w_val2;
      4'b0010, 4'b0011: begin
        w_sum = {1'b0, w_in1} + {1'b0, w_val2}
              + {{WIDTH{1'b0}}, (exe_cmd[0] & status[1])};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_in1[WIDTH-1] == w_val2[WIDTH-1]) && (w_res[WIDTH-1] != w_in1[WIDTH-1]);
      end
      4'b0100, 4'b0101: begin
        w_sum = {1'b0, w_in1} + {1'b0, ~w_val2}
              + {{WIDTH{1'b0}}, (exe_cmd[0] ? status[1] : 1'b1)};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_in1[WIDTH-1] != w_val2[WIDTH-1]) && (w_res[WIDTH-1] != w_in1[WIDTH-1]);
      end
      4'b0110: w_res = w_in1 & w_val2;
      4'b0111: w_res = w_in1 | w_val2;
      4'b1000: w_res = w_in1 ^ w_val2;
      default: w_res = '0;
    endcase
  end

  // One radix-2^MUL_BITS step: add shifted multiplicand for each set multiplier bit.
  always_comb begin
    w_pp = r_acc;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
    end
  end

  assign w_br = pc + ({{(WIDTH-24){signed_imm_24[23]}}, signed_imm_24} << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_mul_rm     <= '0;
      r_mul_s      <= 1'b0;
      out_valid    <= 1'b0;
      alu_res      <= '0;
      val_rm_out   <= '0;
      br_addr      <= '0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      status       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (mul_en) begin
              r_mcand   <= w_in1;
              r_mplier  <= w_rm_f;
              r_mul_rm  <= w_rm_f;
              r_mul_s   <= s_bit;
              r_acc     <= '0;
              r_count   <= c_cnt_w'(c_iters);
              r_state   <= S_MUL;
              out_valid <= 1'b0;
            end else begin
              out_valid    <= 1'b1;
              alu_res      <= w_res;
              val_rm_out   <= w_rm_f;
              br_addr      <= w_br;
              mem_r_en_out <= mem_r_en;
              mem_w_en_out <= mem_w_en;
              if (s_bit) status <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
            end
          end else if (!freeze) begin
            out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc    <= w_pp;
          r_mcand  <= r_mcand << MUL_BITS;
          r_mplier <= r_mplier >> MUL_BITS;
          r_count  <= r_count - 1'b1;
          if (r_count == c_cnt_w'(1)) r_state <= S_DONE;
          if (!freeze) out_valid <= 1'b0;
        end
        S_DONE: begin
          if (!freeze) begin
            out_valid    <= 1'b1;
            alu_res      <= r_acc;
            val_rm_out   <= r_mul_rm;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            if (r_mul_s) status[3:2] <= {r_acc[WIDTH-1], (r_acc == '0)};
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
`default_nettype none
// ============================================================================
// tb_exe_stage_mc : directed self-checking bench for exe_stage_mc.
// Revision 1.0 : initial release
// ============================================================================
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        ready;
  logic        freeze;
  logic [3:0]  exe_cmd;
  logic        mul_en;
  logic        s_bit;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] pc;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] mem_fwd;
  logic [31:0] wb_fwd;
  logic        out_valid;
  logic [31:0] alu_res;
  logic [31:0] val_rm_out;
  logic [31:0] br_addr;
  logic        mem_r_en_out;
  logic        mem_w_en_out;
  logic [3:0]  status;

  int passed = 0;
  int total  = 0;
  int n;

  exe_stage_mc #(.WIDTH(32), .MUL_BITS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ready(ready), .freeze(freeze),
    .exe_cmd(exe_cmd), .mul_en(mul_en), .s_bit(s_bit),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .pc(pc),
    .val_rn(val_rn), .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .out_valid(out_valid), .alu_res(alu_res),
    .val_rm_out(val_rm_out), .br_addr(br_addr), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .status(status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic op(input logic [3:0] cmd, input logic s, input logic im,
                    input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
    exe_cmd       = cmd;
    s_bit         = s;
    imm           = im;
    shift_operand = so;
    val_rn        = rn;
    val_rm        = rm;
    mul_en        = 1'b0;
    mem_r_en      = 1'b0;
    mem_w_en      = 1'b0;
    sel_src1      = 2'd0;
    sel_src2      = 2'd0;
    in_valid      = 1'b1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; in_valid = 1'b0;
    exe_cmd = '0; mul_en = 0; s_bit = 0; mem_r_en = 0; mem_w_en = 0;
    pc = '0; val_rn = '0; val_rm = '0; imm = 0; shift_operand = '0;
    signed_imm_24 = '0; sel_src1 = '0; sel_src2 = '0; mem_fwd = '0; wb_fwd = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_res", alu_res, 32'd0);
    chk("rst_status", {28'd0, status}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);

    // ADDS 0x7FFFFFFF + 1 -> overflow into sign bit
    op(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'd0);
    pc = 32'h100; signed_imm_24 = 24'hFFFFFF;
    tick();
    chk("adds_res", alu_res, 32'h8000_0000);
    chk("adds_status", {28'd0, status}, 32'b1001);
    chk("adds_valid", {31'd0, out_valid}, 32'd1);
    chk("adds_br", br_addr, 32'h0000_00FC);

    op(4'b0100, 1'b1, 1'b1, 12'h005, 32'd5, 32'd0);
    tick();
    chk("subs_res", alu_res, 32'd0);
    chk("subs_status", {28'd0, status}, 32'b0110);

    op(4'b0011, 1'b0, 1'b1, 12'h001, 32'd1, 32'd0);
    tick();
    chk("adc_res", alu_res, 32'd3);
    chk("adc_status_hold", {28'd0, status}, 32'b0110);

    op(4'b0010, 1'b0, 1'b1, 12'hF01, 32'h999, 32'd0);
    sel_src1 = 2'd1; mem_fwd = 32'h10;
    tick();
    chk("fwd_rot_add", alu_res, 32'h14);

    op(4'b0001, 1'b0, 1'b0, 12'h220, 32'd0, 32'hF0);
    tick();
    chk("mov_lsr4", alu_res, 32'h0F);
    chk("mov_rm_out", val_rm_out, 32'hF0);

    op(4'b0010, 1'b0, 1'b0, 12'h008, 32'h1000, 32'd0);
    mem_w_en = 1'b1; sel_src2 = 2'd2; wb_fwd = 32'hABCD;
    tick();
    chk("str_addr", alu_res, 32'h1008);
    chk("str_data", val_rm_out, 32'hABCD);
    chk("str_wen", {31'd0, mem_w_en_out}, 32'd1);

    in_valid = 1'b0;
    tick();
    chk("bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("bubble_hold", alu_res, 32'h1008);

    // MULS 0xFFFFFFFF * 3
    op(4'b0000, 1'b1, 1'b0, 12'h000, 32'hFFFF_FFFF, 32'd3);
    mul_en = 1'b1;
    tick();
    in_valid = 1'b0; mul_en = 1'b0;
    n = 0;
    while (!ready && n < 40) begin
      n++;
      tick();
    end
    chk("mul_stall_cycles", n, 32'd17);
    chk("mul_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_res", alu_res, 32'hFFFF_FFFD);
    chk("mul_status", {28'd0, status}, 32'b1010);

    // Freeze across the end of a multiply
    op(4'b0000, 1'b0, 1'b0, 12'h000, 32'd7, 32'd6);
    mul_en = 1'b1;
    tick();
    in_valid = 1'b0; mul_en = 1'b0;
    repeat (5) tick();
    freeze = 1'b1;
    repeat (15) tick();
    chk("frz_valid", {31'd0, out_valid}, 32'd0);
    chk("frz_ready", {31'd0, ready}, 32'd0);
    chk("frz_res_hold", alu_res, 32'hFFFF_FFFD);
    freeze = 1'b0;
    tick();
    chk("frz_mul_valid", {31'd0, out_valid}, 32'd1);
    chk("frz_mul_res", alu_res, 32'h2A);
    chk("frz_status", {28'd0, status}, 32'b1010);
    freeze = 1'b1;
    tick();
    chk("frz_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("frz_hold_res", alu_res, 32'h2A);
    freeze = 1'b0;
    tick();
    chk("unfrz_bubble", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a multiply
    op(4'b0000, 1'b1, 1'b0, 12'h000, 32'd5, 32'd5);
    mul_en = 1'b1;
    tick();
    in_valid = 1'b0; mul_en = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mrst_res", alu_res, 32'd0);
    chk("mrst_status", {28'd0, status}, 32'd0);
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    chk("mrst_ready", {31'd0, ready}, 32'd1);
    op(4'b0010, 1'b0, 1'b1, 12'h003, 32'd2, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("post_rst_add", alu_res, 32'd5);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    repeat (20) tick();
    chk("no_late_mul", alu_res, 32'd5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
Parametrised, registered execute stage for the ARM pipeline. It adds an iterative multiplier, an internal status register with S-bit update, and a valid/ready/freeze handshake to the usual combinational work: forwarding muxes, val2 generation, the ALU and the branch-target adder. It sits between the ID/EXE register and the MEM stage. It drives its own registered EXE/MEM outputs and stalls upstream while a multiply is in progress.

Parameters:
WIDTH, 32, datapath width; must be at least 32. Immediate rotate and register shifts operate within WIDTH.
MUL_BITS, 2, multiplier bits retired per cycle; must divide WIDTH. A multiply takes WIDTH/MUL_BITS iterations.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  instruction present on the inputs
ready  out  1  = (state==IDLE) && !freeze; an instruction is accepted when in_valid && ready
freeze  in  1  downstream stall; holds the output register
exe_cmd  in  4  ALU op
mul_en  in  1  instruction is MUL
s_bit  in  1  update status
mem_r_en, mem_w_en  in  1 each  load/store
pc  in  WIDTH  PC of the next instruction
val_rn, val_rm  in  WIDTH  register operands
imm  in  1  immediate operand form
shift_operand  in  12  ARM shifter operand field
signed_imm_24  in  24  branch offset
sel_src1, sel_src2  in  2 each  forwarding select: 0 = reg, 1 = mem_fwd, 2 = wb_fwd, 3 = reg
mem_fwd, wb_fwd  in  WIDTH  forwarding values
out_valid  out  1  registered result valid
alu_res  out  WIDTH  registered result
val_rm_out  out  WIDTH  registered forwarded Rm (store data)
br_addr  out  WIDTH  registered pc + (sext(signed_imm_24) << 2)
mem_r_en_out, mem_w_en_out  out  1 each  registered pass-through
status  out  4  SR {N,Z,C,V}

Behaviour:
- Reset: every output register and SR = 0, state = IDLE, out_valid = 0. Reset asserted mid-multiply aborts the multiply; no result is produced.
- Forwarding: in1 = mux(sel_src1), rm_f = mux(sel_src2). Both are sampled only at accept.
- val2 selection:
  - if mem_r_en | mem_w_en: zero-extended shift_operand[11:0].
  - else if imm: zext(shift_operand[7:0]) rotated right by 2*shift_operand[11:8].
  - else: rm_f shifted by shift_operand[11:7]; type [6:5] = LSL / LSR / ASR / ROR.
- ALU ops (Cin = SR.C):
  - 0001 MOV val2; 1001 MVN ~val2.
  - 0010 ADD; 0011 ADC (+Cin).
  - 0100 SUB; 0101 SBC (in1 - val2 - !Cin).
  - 0110 AND; 0111 ORR; 1000 EOR.
  - Other codes: result 0.
- Flags:
  - N = msb of result, Z = (result == 0).
  - Add/sub: C = carry out (SUB: C = NOT borrow), V = signed overflow.
  - Logic/move: C and V unchanged.
  - MUL: N and Z only.
- Non-MUL accept with !freeze: the output register loads at the next edge (latency 1), out_valid = 1. If s_bit, SR loads at the same edge.
- Output register hold/clear: with no accept and !freeze, out_valid clears to 0 and the other outputs hold. Under freeze, all outputs and SR hold.
- FSM IDLE:
  - accept with mul_en: latch in1, rm_f, s_bit; clear accumulator; go to MUL; count = WIDTH/MUL_BITS.
  - out_valid clears at the next edge (bubble) unless freeze.
- FSM MUL:
  - Each cycle, add the partial products of MUL_BITS multiplier bits.
  - Count decrements regardless of freeze.
  - When count reaches 0, go to DONE.
- FSM DONE: when !freeze, write the low WIDTH bits of the product to alu_res, set out_valid = 1, update SR.N/Z if s_bit, then go to IDLE.
- Upstream stall: ready = 0 in MUL and DONE. in_valid is ignored while !ready, and the upstream holds its instruction.
- Multiply latency: WIDTH/MUL_BITS + 1 cycles from accept to out_valid with no freeze (16 + 1 = 17 at the defaults).
- Arithmetic wraps modulo 2^WIDTH. br_addr, val_rm_out and the mem flags are registered alongside alu_res.

Test Plan:
- ADDS with in1 = 0x7FFFFFFF, imm 0x001 -> next cycle alu_res = 0x80000000, status = 1001 (N = 1, V = 1), out_valid = 1.
- SUBS 5 - 5, then ADC 1 + 1 -> first gives status Z = 1, C = 1; ADC alu_res = 3.
- sel_src1 = 1 with mem_fwd = 0x10, MOV-free ADD with val2 = imm rotate (shift_operand = 0xF01 → 0x4) -> alu_res = 0x14. A register LSR #4 of 0xF0 -> 0x0F.
- MULS 0xFFFFFFFF * 3 -> ready low for 17 cycles; alu_res = 0xFFFFFFFD, N = 1, C/V unchanged.
- Freeze asserted during MUL and held 3 cycles past the end -> result delivered only after freeze drops; outputs stable while frozen.
- rst pulsed mid-multiply -> all outputs 0, ready = 1 next cycle; a following ADD executes normally.
